// File: rtl/reg_file_pkg.sv
// Shared sizes and types for the register file read side.
// Register 0 is hardwired to zero throughout.
package reg_file_pkg;
   localparam int NUM_REGS = 8;
   localparam int DATA_W   = 8;
   localparam int IDX_W    = $clog2(NUM_REGS);

   typedef logic [DATA_W-1:0]   word_t;
   typedef logic [IDX_W-1:0]    reg_idx_t;
   typedef word_t [NUM_REGS-1:0] reg_bank_t;
endpackage

// File: rtl/operand_select.sv
// One source operand: zero register, write-back bypass, array read,
// plus the scoreboard hazard flag for that source.
module operand_select
   import reg_file_pkg::*;
(
   input  reg_idx_t            idx,
   input  reg_bank_t           reg_data,
   input  logic                wb_en,
   input  reg_idx_t            wb_addr,
   input  word_t               wb_data,
   input  logic [NUM_REGS-1:0] busy_mask,
   output word_t               data,
   output logic                blocked
);
   logic hit;

   always_comb begin
      hit = wb_en && (wb_addr == idx);
      data = reg_data[idx];
      if (idx == '0) begin
         data = '0;
      end else if (hit) begin
         data = wb_data;
      end
      // A write-back landing this cycle resolves the hazard.
      blocked = (idx != '0) && busy_mask[idx] && !hit;
   end
endmodule

// File: rtl/register_read_port.sv
// Two-operand fetch with bypass, pending-write scoreboard and a
// single-entry valid/ready output slot.
module register_read_port
   import reg_file_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  reg_bank_t           reg_data,
   input  logic                req_valid,
   output logic                req_ready,
   input  reg_idx_t            req_rs1,
   input  reg_idx_t            req_rs2,
   input  logic                req_rd_valid,
   input  reg_idx_t            req_rd,
   input  logic                wb_en,
   input  reg_idx_t            wb_addr,
   input  word_t               wb_data,
   output logic                op_valid,
   input  logic                op_ready,
   output word_t               op_a,
   output word_t               op_b,
   output reg_idx_t            op_rd,
   output logic                op_rd_valid,
   output logic [NUM_REGS-1:0] busy_mask
);
   word_t               a_data;
   word_t               b_data;
   logic                a_blk;
   logic                b_blk;
   logic                accept;
   logic                op_valid_q;
   logic                op_valid_d;
   word_t               op_a_q;
   word_t               op_a_d;
   word_t               op_b_q;
   word_t               op_b_d;
   reg_idx_t            op_rd_q;
   reg_idx_t            op_rd_d;
   logic                op_rd_valid_q;
   logic                op_rd_valid_d;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   operand_select u_rs1 (
      .idx       (req_rs1),
      .reg_data  (reg_data),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .busy_mask (busy_q),
      .data      (a_data),
      .blocked   (a_blk)
   );

   operand_select u_rs2 (
      .idx       (req_rs2),
      .reg_data  (reg_data),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .busy_mask (busy_q),
      .data      (b_data),
      .blocked   (b_blk)
   );

   always_comb begin
      req_ready = rst && !a_blk && !b_blk && (!op_valid_q || op_ready);
      accept = req_valid && req_ready;
      op_valid_d = op_valid_q;
      op_a_d = op_a_q;
      op_b_d = op_b_q;
      op_rd_d = op_rd_q;
      op_rd_valid_d = op_rd_valid_q;
      if (accept) begin
         op_valid_d = 1'b1;
         op_a_d = a_data;
         op_b_d = b_data;
         op_rd_d = req_rd;
         op_rd_valid_d = req_rd_valid;
      end else if (op_valid_q && op_ready) begin
         op_valid_d = 1'b0;
      end
      busy_d = busy_q;
      if (wb_en && (wb_addr != '0)) begin
         busy_d[wb_addr] = 1'b0;
      end
      // Set after clear: the newly issued writer is younger.
      if (accept && req_rd_valid && (req_rd != '0)) begin
         busy_d[req_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_valid_q <= 1'b0;
         op_a_q <= '0;
         op_b_q <= '0;
         op_rd_q <= '0;
         op_rd_valid_q <= 1'b0;
         busy_q <= '0;
      end else begin
         op_valid_q <= op_valid_d;
         op_a_q <= op_a_d;
         op_b_q <= op_b_d;
         op_rd_q <= op_rd_d;
         op_rd_valid_q <= op_rd_valid_d;
         busy_q <= busy_d;
      end
   end

   assign op_valid = op_valid_q;
   assign op_a = op_a_q;
   assign op_b = op_b_q;
   assign op_rd = op_rd_q;
   assign op_rd_valid = op_rd_valid_q;
   assign busy_mask = busy_q;
endmodule

// File: tb/tb_register_read_port.sv
// Directed and random checks of register_read_port against a
// per-cycle behavioural model of the operand slot and scoreboard.
module tb_register_read_port;
   import reg_file_pkg::*;

   logic                clk;
   logic                rst;
   reg_bank_t           regs;
   logic                req_valid;
   logic                req_ready;
   reg_idx_t            req_rs1;
   reg_idx_t            req_rs2;
   logic                req_rd_valid;
   reg_idx_t            req_rd;
   logic                wb_en;
   reg_idx_t            wb_addr;
   word_t               wb_data;
   logic                op_valid;
   logic                op_ready;
   word_t               op_a;
   word_t               op_b;
   reg_idx_t            op_rd;
   logic                op_rd_valid;
   logic [NUM_REGS-1:0] busy_mask;

   int nvec = 0;
   int nerr = 0;

   bit       m_v;
   word_t    m_a;
   word_t    m_b;
   reg_idx_t m_rd;
   bit       m_rdv;
   bit       m_busy [NUM_REGS];

   word_t hold_a;
   word_t hold_b;

   register_read_port dut (
      .clk          (clk),
      .rst          (rst),
      .reg_data     (regs),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_rd_valid (req_rd_valid),
      .req_rd       (req_rd),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_rd        (op_rd),
      .op_rd_valid  (op_rd_valid),
      .busy_mask    (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit blocked(input int s);
      return s != 0 && m_busy[s] && !(wb_en && int'(wb_addr) == s);
   endfunction

   function automatic word_t read_src(input int s);
      if (s == 0) return '0;
      if (wb_en && int'(wb_addr) == s) return wb_data;
      return regs[s];
   endfunction

   function automatic logic [7:0] busy_vec();
      logic [7:0] v;
      for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic cycle();
      bit rdy;
      bit acc;
      @(negedge clk);
      rdy = rst && !blocked(int'(req_rs1)) && !blocked(int'(req_rs2))
            && (!m_v || op_ready);
      acc = req_valid && rdy;
      chk("req_ready", 8'(req_ready), 8'(rdy));
      chk("op_valid", 8'(op_valid), 8'(m_v));
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
      chk("op_rd", 8'(op_rd), 8'(m_rd));
      chk("op_rd_valid", 8'(op_rd_valid), 8'(m_rdv));
      chk("busy_mask", busy_mask, busy_vec());
      @(posedge clk);
      if (!rst) begin
         m_v = 0; m_a = '0; m_b = '0; m_rd = '0; m_rdv = 0;
         for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
      end else begin
         if (acc) begin
            m_v = 1;
            m_a = read_src(int'(req_rs1));
            m_b = read_src(int'(req_rs2));
            m_rd = req_rd;
            m_rdv = req_rd_valid;
         end else if (m_v && op_ready) begin
            m_v = 0;
         end
         if (wb_en && wb_addr != 0) m_busy[wb_addr] = 0;
         if (acc && req_rd_valid && req_rd != 0) m_busy[req_rd] = 1;
      end
      if (wb_en) regs[wb_addr] = wb_data;
      #1;
   endtask

   task automatic req(input int rs1, input int rs2, input bit rdv,
                      input int rd);
      req_valid = 1'b1;
      req_rs1 = reg_idx_t'(rs1);
      req_rs2 = reg_idx_t'(rs2);
      req_rd_valid = rdv;
      req_rd = reg_idx_t'(rd);
   endtask

   initial begin
      rst = 1'b0;
      regs = '0;
      req_valid = 1'b0;
      req_rs1 = '0;
      req_rs2 = '0;
      req_rd_valid = 1'b0;
      req_rd = '0;
      wb_en = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      op_ready = 1'b1;
      m_v = 0; m_a = '0; m_b = '0; m_rd = '0; m_rdv = 0;
      for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
      @(posedge clk);
      #1;
      cycle();
      req(3, 5, 0, 0);
      cycle();
      cycle();
      chk("rst_op_valid", 8'(op_valid), 8'h00);
      chk("rst_busy", busy_mask, 8'h00);
      #1 chk("rst_ready", 8'(req_ready), 8'h00);

      rst = 1'b1;
      regs[3] = 8'h5A;
      regs[5] = 8'hC3;
      #1 chk("ready_after_rst", 8'(req_ready), 8'h01);
      cycle();
      chk("basic_valid", 8'(op_valid), 8'h01);
      chk("basic_a", op_a, 8'h5A);
      chk("basic_b", op_b, 8'hC3);

      regs[0] = 8'hFF;
      regs[4] = 8'h11;
      req(0, 4, 0, 0);
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h77;
      cycle();
      wb_en = 1'b0;
      chk("zero_reg", op_a, 8'h00);
      chk("bypass", op_b, 8'h77);

      req(1, 1, 1, 2);
      cycle();
      chk("sb_set", busy_mask, 8'h04);
      req(2, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("sb_stall", 8'(req_ready), 8'h00);
         cycle();
      end
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h3C;
      #1 chk("sb_release", 8'(req_ready), 8'h01);
      cycle();
      wb_en = 1'b0;
      chk("sb_bypass_a", op_a, 8'h3C);
      chk("sb_clear", busy_mask, 8'h00);

      req(3, 5, 0, 0);
      cycle();
      hold_a = op_a;
      hold_b = op_b;
      op_ready = 1'b0;
      req(1, 1, 0, 0);
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h99;
      for (int i = 0; i < 4; i++) begin
         #1 chk("bp_ready", 8'(req_ready), 8'h00);
         cycle();
         wb_en = 1'b0;
         chk("bp_hold_a", op_a, hold_a);
         chk("bp_hold_b", op_b, hold_b);
      end
      op_ready = 1'b1;
      req(3, 5, 0, 0);
      cycle();
      chk("b2b_valid", 8'(op_valid), 8'h01);
      chk("b2b_a", op_a, 8'h99);

      req(1, 1, 1, 2);
      cycle();
      req(0, 0, 1, 2);
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h42;
      cycle();
      chk("set_wins", busy_mask, 8'h04);
      req_valid = 1'b0;
      cycle();
      wb_en = 1'b0;
      chk("final_clear", busy_mask, 8'h00);

      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(59) != 0);
         req_valid = $urandom_range(3) != 0;
         req_rs1 = reg_idx_t'($urandom_range(7));
         req_rs2 = reg_idx_t'($urandom_range(7));
         req_rd_valid = $urandom_range(1) != 0;
         req_rd = reg_idx_t'($urandom_range(7));
         wb_en = $urandom_range(2) == 0;
         wb_addr = reg_idx_t'($urandom_range(7));
         wb_data = word_t'($urandom);
         op_ready = $urandom_range(3) != 0;
         if ($urandom_range(7) == 0)
            regs[$urandom_range(7)] = word_t'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/register_read_port.md
Name: register_read_port

Overview:
- Read-side companion to the 8x8 register array: two-operand fetch unit feeding the ALU/execute stage.
- Accepts a read request (rs1, rs2, optional destination rd) over a valid/ready handshake and returns both 8-bit operands one cycle later over a valid/ready handshake.
- Provides write-back bypass, so a value written in the same cycle is seen.
- Provides a pending-write scoreboard that stalls requests whose sources are not yet written back.

Parameters:
- NUM_REGS, 8, number of architectural registers; register 0 reads as constant zero.
- DATA_W, 8, register width in bits.
- IDX_W, 3, register index width, equal to clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- reg_data  input  NUM_REGS x DATA_W  current contents of every register, from the register array outputs.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_rs1  input  IDX_W  source index A.
- req_rs2  input  IDX_W  source index B.
- req_rd_valid  input  1  request will write a destination register.
- req_rd  input  IDX_W  destination index.
- wb_en  input  1  write-back this cycle; same strobe that drives the array write enable.
- wb_addr  input  IDX_W  write-back index.
- wb_data  input  DATA_W  write-back data.
- op_valid  output  1  operands valid.
- op_ready  input  1  consumer accepts operands.
- op_a  output  DATA_W  operand for rs1.
- op_b  output  DATA_W  operand for rs2.
- op_rd  output  IDX_W  destination forwarded with operands.
- op_rd_valid  output  1  destination-valid flag forwarded with operands.
- busy_mask  output  NUM_REGS  scoreboard; bit i set means a write to register i is outstanding.

Behaviour:
- Reset: when rst==0 at a clk edge, all of the following clear to zero: op_valid, op_a, op_b, op_rd, op_rd_valid, busy_mask. Any request in flight is discarded. req_ready reads 0 while rst==0.
- Source resolution, per operand:
  - Index 0 gives 0.
  - Otherwise, if wb_en && wb_addr==index, the result is wb_data (bypass).
  - Otherwise the result is reg_data[index].
- Hazard: source index s is blocked when s!=0, busy_mask[s]==1, and NOT (wb_en && wb_addr==s).
- Output slot state: holds no operand pair (op_valid=0) or holds one (op_valid=1).
- req_ready = rst && (no source blocked) && (!op_valid || op_ready). It is combinational and must not depend on req_valid.
- Accept: on req_valid && req_ready the operand pair, rd and rd_valid are registered. op_valid=1 on the next cycle, giving latency 1.
- Stall: when op_valid && !op_ready, op_a, op_b, op_rd and op_rd_valid hold stable.
- Stall hazard: a write-back during the stall does NOT update the held operands. The hazard check at accept time guarantees correctness.
- Drain: op_valid && op_ready && !(new accept) sets op_valid to 0 next cycle.
- Back-to-back: op_ready together with an accept in the same cycle loads new data with no bubble.
- Scoreboard set: on accept with req_rd_valid && req_rd!=0, the busy bit for req_rd is set.
- Scoreboard clear: wb_en && wb_addr!=0 clears the busy bit for wb_addr.
- Same-index set and clear in one cycle: the set wins, because the new issue is younger.
- Writes to register 0 never set busy; busy_mask[0] is always 0.
- A request whose rd equals one of its own sources reads the old value and then marks busy.
- Index arithmetic is unsigned; no out-of-range indices exist when NUM_REGS==2**IDX_W.

Decomposition:
- Package reg_file_pkg holds NUM_REGS, DATA_W, IDX_W, typedef word_t (logic [DATA_W-1:0]), typedef reg_idx_t (logic [IDX_W-1:0]), and typedef reg_bank_t (word_t [NUM_REGS-1:0]).
- Sub-module operand_select (combinational): zero-register, bypass and array select for one operand, plus its blocked flag. It is instantiated twice (rs1, rs2).
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset, then hold rst=0 for 2 cycles with req_valid=1 -> op_valid=0, busy_mask=8'h00, req_ready=0. Release -> req_ready=1.
- reg_data[3]=8'h5A, reg_data[5]=8'hC3; request rs1=3, rs2=5, rd_valid=0 -> next cycle op_valid=1, op_a=8'h5A, op_b=8'hC3.
- Request rs1=0, rs2=4 with reg_data[0] forced to 8'hFF -> op_a=8'h00.
- Bypass: same-cycle wb_en=1, wb_addr=4, wb_data=8'h77 with reg_data[4]=8'h11 -> op_b=8'h77.
- Scoreboard: issue rd_valid=1, rd=2 -> busy_mask=8'h04.
  - Next request rs1=2 -> req_ready=0 for 3 cycles.
  - Then wb_en=1, wb_addr=2, wb_data=8'h3C -> accepted that cycle, op_a=8'h3C, busy_mask=8'h00.
- Backpressure: op_ready=0 for 4 cycles after an accept -> op_a and op_b stable, req_ready=0.
  - Then op_ready=1 with req_valid=1 -> new pair on the next cycle with no bubble.
  - wb to rd=2 coincident with a new issue of rd=2 -> busy_mask[2] stays 1.
